// File: rtl/edge_event_arbiter_if.sv
// rtl/edge_event_arbiter_if.sv - valid/ready event port shared by the arbiter and its consumer
//
// Purpose: bundles the single downstream event handshake.
// Signals:
//   evt_valid  event offered to the consumer (driven by master)
//   evt_ready  consumer accepts when evt_valid & evt_ready at posedge clk (driven by slave)
//   evt_id     channel index of the offered event (driven by master)
//   evt_rise   edge type of the offered event, 1 rising / 0 falling (driven by master)
// Modports: master = arbiter side, slave = consumer side.
interface edge_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_rise;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_rise,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_rise,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - multi-channel edge-event detector with round-robin event serialiser
//
// Purpose: detects edges on N clk-synchronous level inputs, latches each as a pending
// event and offers the events one at a time, round-robin, on a valid/ready port.
// A sticky per-channel overrun flag records events lost while one was already pending.
// Optional feature macro: EDGE_BOTH_EN - when defined, falling edges also create events
// (evt_rise=0); when undefined only rising edges count and evt_rise is tied to 1.
// Ports:
//   clk      system clock, all logic on posedge
//   reset    asynchronous active-high reset
//   level    [N-1:0] synchronous level inputs
//   evt      event port (edge_event_arbiter_if.master): evt_valid/evt_ready/evt_id/evt_rise
//   pending  [N-1:0] registered per-channel pending-event flags
//   overrun  [N-1:0] sticky per-channel lost-event flags
//   ovr_clr  single-cycle pulse clearing all overrun bits
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                level,
  edge_event_arbiter_if.master        evt,
  output logic [N-1:0]                pending,
  output logic [N-1:0]                overrun,
  input  logic                        ovr_clr
);

  // One-hot encoding so that the two unused codes are detectable and recovered to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    OFFER = 2'b10
  } state_t;

  localparam logic [ID_W:0]   N_W   = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] LAST  = ID_W'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    prev_q;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ovr_q, ovr_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;

  logic [N-1:0]    rise_v;
  logic [N-1:0]    edge_v;
  logic [N-1:0]    clr_v;
  logic            hs;
  logic            found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W:0]   scan;
  logic [ID_W-1:0] ptr_inc;

`ifdef EDGE_BOTH_EN
  logic [N-1:0]    fall_v;
  logic [N-1:0]    type_q, type_d;
  logic            rise_q, rise_d;
`endif

  // ---------------- edge detect and pending/overrun bookkeeping ----------------
  always_comb begin
    rise_v = level & ~prev_q;
`ifdef EDGE_BOTH_EN
    fall_v = ~level & prev_q;
    edge_v = rise_v | fall_v;
    // Remember the type of the most recent edge per channel.
    type_d = (type_q & ~edge_v) | (rise_v & edge_v);
`else
    edge_v = rise_v;
`endif

    hs    = valid_q & evt.evt_ready;
    clr_v = '0;
    for (int i = 0; i < N; i++) begin
      if (hs && (id_q == ID_W'(i))) clr_v[i] = 1'b1;
    end

    // A new edge in the handshake cycle of its own channel re-arms the flag.
    pend_d = (pend_q & ~clr_v) | edge_v;
    // Setting an overrun takes precedence over a simultaneous clear.
    ovr_d  = (ovr_clr ? '0 : ovr_q) | (edge_v & pend_q & ~clr_v);
  end

  // ---------------- round-robin pick starting at ptr ----------------
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    scan    = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan >= N_W) scan = scan - N_W;
      if (!found && pend_q[scan[ID_W-1:0]]) begin
        found   = 1'b1;
        pick_id = scan[ID_W-1:0];
      end
    end
  end

  // The channel just granted becomes lowest priority next time.
  assign ptr_inc = (id_q == LAST) ? '0 : id_q + ID_W'(1);

  // ---------------- FSM next-state / outputs ----------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    id_d    = id_q;
`ifdef EDGE_BOTH_EN
    rise_d  = rise_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (found) begin
          valid_d = 1'b1;
          id_d    = pick_id;
`ifdef EDGE_BOTH_EN
          rise_d  = type_q[pick_id];
`endif
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Offer is held stable until accepted; no withdrawal.
        if (hs) begin
          valid_d = 1'b0;
          ptr_d   = ptr_inc;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= level;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

`ifdef EDGE_BOTH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q <= '1;
      rise_q <= 1'b1;
    end else begin
      type_q <= type_d;
      rise_q <= rise_d;
    end
  end

  assign evt.evt_rise = rise_q;
`else
  assign evt.evt_rise = 1'b1;
`endif

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] level;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         ovr_clr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  edge_event_arbiter_if #(.ID_W(ID_W)) evt ();

  edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .level   (level),
    .evt     (evt),
    .pending (pending),
    .overrun (overrun),
    .ovr_clr (ovr_clr)
  );

  always #5 clk = ~clk;

  // Reference model: channel-level view of the spec's rules.
  bit m_prev [N];
  bit m_pend [N];
  bit m_type [N];
  bit m_ovr  [N];
  int m_ptr;
  bit m_busy;
  int m_id;
  bit m_rise;

  // Handshake log (observed at the accepting edge).
  int log_id   [$];
  int log_rise [$];
  int log_cyc  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pack(input bit v [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic int pick_from(input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (m_pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_type[i] = 1; m_ovr[i] = 0;
    end
    m_ptr = 0; m_busy = 0; m_id = 0; m_rise = 1;
  endtask

  task automatic model_update(input logic [N-1:0] lvl, input bit rdy, input bit clr);
    bit hs;
    bit e [N];
    bit r [N];
    hs = m_busy && rdy;
    for (int i = 0; i < N; i++) begin
      r[i] = lvl[i] && !m_prev[i];
`ifdef EDGE_BOTH_EN
      e[i] = r[i] || (!lvl[i] && m_prev[i]);
`else
      e[i] = r[i];
`endif
    end
    if (!m_busy) begin
      int c;
      c = pick_from(m_ptr);
      if (c >= 0) begin
        m_busy = 1; m_id = c; m_rise = m_type[c];
      end
    end else if (hs) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      bit cleared;
      cleared = hs && (m_id == i);
      if (clr) m_ovr[i] = 0;
      if (e[i] && m_pend[i] && !cleared) m_ovr[i] = 1;
      if (e[i]) begin
        m_pend[i] = 1;
        m_type[i] = r[i];
      end else if (cleared) begin
        m_pend[i] = 0;
      end
      m_prev[i] = lvl[i];
    end
  endtask

  task automatic compare_all();
    chk("evt_valid", 32'(evt.evt_valid), 32'(m_busy));
    if (m_busy) begin
      chk("evt_id", 32'(evt.evt_id), 32'(m_id));
      chk("evt_rise", 32'(evt.evt_rise), 32'(m_rise));
    end
    chk("pending", 32'(pending), 32'(pack(m_pend)));
    chk("overrun", 32'(overrun), 32'(pack(m_ovr)));
  endtask

  task automatic step(input logic [N-1:0] lvl, input bit rdy, input bit clr);
    level         = lvl;
    evt.evt_ready = rdy;
    ovr_clr       = clr;
    #1;
    if (evt.evt_valid && rdy) begin
      log_id.push_back(int'(evt.evt_id));
      log_rise.push_back(int'(evt.evt_rise));
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_update(lvl, rdy, clr);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic [N-1:0] lvl);
    reset         = 1'b1;
    level         = lvl;
    evt.evt_ready = 1'b0;
    ovr_clr       = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    chk("rst_valid", 32'(evt.evt_valid), 32'd0);
    chk("rst_id", 32'(evt.evt_id), 32'd0);
    chk("rst_rise", 32'(evt.evt_rise), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    log_id.delete(); log_rise.delete(); log_cyc.delete();
  endtask

  initial begin
    logic [N-1:0] cur;

    // 1: level held high across reset release -> exactly one id 0 event
    do_reset(4'b0001);
    step(4'b0001, 1, 0);
    chk("t1_pending", 32'(pending), 32'b0001);
    chk("t1_valid_early", 32'(evt.evt_valid), 32'd0);
    step(4'b0001, 1, 0);
    chk("t1_valid", 32'(evt.evt_valid), 32'd1);
    chk("t1_id", 32'(evt.evt_id), 32'd0);
    repeat (6) step(4'b0001, 1, 0);
    chk("t1_count", 32'(log_id.size()), 32'd1);

    // 2: all channels rise together -> ids 0..3, two cycles apart
    do_reset(4'b0000);
    repeat (12) step(4'b1111, 1, 0);
    chk("t2_count", 32'(log_id.size()), 32'd4);
    if (log_id.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", 32'(log_id[i]), 32'(i));
      for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);
    end

    // 3: stall on id 2 for 10 cycles, then accept
    do_reset(4'b0000);
    repeat (2) step(4'b0100, 0, 0);
    repeat (10) step(4'b0100, 0, 0);
    chk("t3_valid_held", 32'(evt.evt_valid), 32'd1);
    chk("t3_id_held", 32'(evt.evt_id), 32'd2);
    step(4'b0100, 1, 0);
    chk("t3_cleared", 32'(pending), 32'd0);
    chk("t3_valid_drop", 32'(evt.evt_valid), 32'd0);

    // 4: ch1 rise/fall/rise while unserviced -> overrun, then clear
    do_reset(4'b0000);
    step(4'b0010, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0010, 0, 0);
    chk("t4_overrun", 32'(overrun), 32'b0010);
    step(4'b0010, 0, 1);
    chk("t4_ovr_clr", 32'(overrun), 32'b0000);
    repeat (3) step(4'b0010, 1, 0);

    // 5: ch0 re-rises in its own handshake cycle
    do_reset(4'b0000);
    step(4'b0001, 0, 0);
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0001, 1, 0);
    chk("t5_pending_kept", 32'(pending[0]), 32'd1);
`ifndef EDGE_BOTH_EN
    chk("t5_no_overrun", 32'(overrun), 32'd0);
`endif
    repeat (4) step(4'b0001, 1, 0);
    chk("t5_two_events", 32'(log_id.size()), 32'd2);

`ifdef EDGE_BOTH_EN
    // 6: ch3 pulse with service in between -> rise then fall event
    do_reset(4'b0000);
    repeat (4) step(4'b1000, 1, 0);
    repeat (4) step(4'b0000, 1, 0);
    chk("t6_count", 32'(log_id.size()), 32'd2);
    if (log_id.size() == 2) begin
      chk("t6_id0", 32'(log_id[0]), 32'd3);
      chk("t6_rise0", 32'(log_rise[0]), 32'd1);
      chk("t6_id1", 32'(log_id[1]), 32'd3);
      chk("t6_rise1", 32'(log_rise[1]), 32'd0);
    end
`endif

    // Reset asserted mid-offer drops evt_valid immediately
    do_reset(4'b0000);
    repeat (2) step(4'b0100, 0, 0);
    chk("mid_valid_pre", 32'(evt.evt_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid_async", 32'(evt.evt_valid), 32'd0);
    chk("mid_pending_async", 32'(pending), 32'd0);
    do_reset(4'b0000);

    // Randomized traffic against the model
    cur = '0;
    for (int n = 0; n < 600; n++) begin
      cur = cur ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      step(cur, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
